// File: rtl/motor_input_conditioner.sv
// Input front end for the DC-motor designs: 2-FF synchronisers, per-channel
// debounce counters, a direction interlock on SW and a one-cycle run-press pulse.
module motor_input_conditioner #(
  parameter logic [20:0] DEBOUNCE_TIME = 21'd1249999,
  parameter logic        LOCK_DIR      = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_IN,
  input  logic BTN_IN,
  input  logic PWM_EN_IN,
  output logic SW,
  output logic BTN,
  output logic PWM_EN,
  output logic BTN_PRESS,
  output logic DIR_PENDING
);

  // Synchroniser bit order: {pwm, btn, sw}
  logic [2:0]  s1, s2;
  logic [20:0] cnt_sw, cnt_btn, cnt_pwm;
  logic        sw_diff, btn_diff, pwm_diff;
  logic        sw_full, btn_full, pwm_full;
  logic        sw_blocked;

  always_comb begin
    sw_diff    = s2[0] != SW;
    btn_diff   = s2[1] != BTN;
    pwm_diff   = s2[2] != PWM_EN;
    sw_full    = cnt_sw  == DEBOUNCE_TIME;
    btn_full   = cnt_btn == DEBOUNCE_TIME;
    pwm_full   = cnt_pwm == DEBOUNCE_TIME;
    sw_blocked = LOCK_DIR & BTN;
  end

  assign DIR_PENDING = sw_blocked & sw_full & sw_diff;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1        <= '0;
      s2        <= '0;
      cnt_sw    <= '0;
      cnt_btn   <= '0;
      cnt_pwm   <= '0;
      SW        <= 1'b0;
      BTN       <= 1'b0;
      PWM_EN    <= 1'b0;
      BTN_PRESS <= 1'b0;
    end else begin
      s1 <= {PWM_EN_IN, BTN_IN, SW_IN};
      s2 <= s1;

      if (!btn_diff) begin
        cnt_btn <= '0;
      end else if (!btn_full) begin
        cnt_btn <= cnt_btn + 21'd1;
      end else begin
        BTN     <= ~BTN;
        cnt_btn <= '0;
      end
      BTN_PRESS <= btn_diff & btn_full & ~BTN;

      if (!pwm_diff) begin
        cnt_pwm <= '0;
      end else if (!pwm_full) begin
        cnt_pwm <= cnt_pwm + 21'd1;
      end else begin
        PWM_EN  <= ~PWM_EN;
        cnt_pwm <= '0;
      end

      // While the run level is held the qualified direction change parks at N
      // and is released on the first edge that sees BTN low beforehand.
      if (!sw_diff) begin
        cnt_sw <= '0;
      end else if (!sw_full) begin
        cnt_sw <= cnt_sw + 21'd1;
      end else if (!sw_blocked) begin
        SW     <= ~SW;
        cnt_sw <= '0;
      end
    end
  end

endmodule
